dso100fb_fetch_ctrl: RTL and testbench

DSO100FB_FETCH_CTRL -- requirements
Module: dso100fb_fetch_ctrl

---
 rtl/dso100fb_pkg.sv | 59 +++++
 rtl/dso100fb_outst_cnt.sv | 53 +++++
 rtl/dso100fb_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dso100fb_fetch_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dso100fb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dso100fb_pkg                                                             |
// | Shared types and constants for the DSO100 framebuffer fetch controller: |
// | fetch FSM state enum, DataMover MM2S command field offsets, status bit    |
// | indices and the command builder / status decode helpers.                 |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package dso100fb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   // MM2S command word layout
   localparam int CMD_W        = 72;
   localparam int CMD_TAG_LSB  = 64;
   localparam int CMD_TAG_W    = 4;
   localparam int CMD_ADDR_LSB = 32;
   localparam int CMD_ADDR_W   = 32;
   localparam int CMD_EOF_BIT  = 30;
   localparam int CMD_INCR_BIT = 23;
   localparam int CMD_BTT_W    = 23;

   localparam logic CMD_INCR = 1'b1;
   localparam logic CMD_EOF  = 1'b1;

   // MM2S status byte layout
   localparam int STS_OKAY_BIT   = 7;
   localparam int STS_SLVERR_BIT = 6;
   localparam int STS_DECERR_BIT = 5;
   localparam int STS_INTERR_BIT = 4;

   // Reserved, DRR and DSA fields are all left at zero.
   function automatic logic [CMD_W-1:0] mm2s_cmd(
      input logic [CMD_TAG_W-1:0]  tag,
      input logic [CMD_ADDR_W-1:0] addr,
      input logic                  eof,
      input logic [CMD_BTT_W-1:0]  btt
   );
      logic [CMD_W-1:0] c;
      c                                = '0;
      c[CMD_TAG_LSB +: CMD_TAG_W]      = tag;
      c[CMD_ADDR_LSB +: CMD_ADDR_W]    = addr;
      c[CMD_EOF_BIT]                   = eof;
      c[CMD_INCR_BIT]                  = CMD_INCR;
      c[CMD_BTT_W-1:0]                 = btt;
      return c;
   endfunction

   function automatic logic sts_is_err(input logic [7:0] sts);
      return !sts[STS_OKAY_BIT] || sts[STS_SLVERR_BIT] ||
             sts[STS_DECERR_BIT] || sts[STS_INTERR_BIT];
   endfunction

endpackage
`default_nettype wire

// File: rtl/dso100fb_outst_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dso100fb_outst_cnt                                                       |
// | Saturating up/down counter of DataMover commands awaiting status.       |
// | Ports: CLK, RST_N (async, active-low), inc_i (command accepted),        |
// |        dec_i (status received), full_o (count >= MAX_CNT),              |
// |        empty_o (count == 0).                                            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module dso100fb_outst_cnt #(
   parameter int MAX_CNT = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic inc_i,
   input  logic dec_i,
   output logic full_o,
   output logic empty_o
);
   localparam int                CNT_W = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0]  C_MAX = CNT_W'(MAX_CNT);
   localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             w_inc;
   logic             w_dec;

   assign full_o  = (cnt_q >= C_MAX);
   assign empty_o = (cnt_q == '0);

   // A decrement at zero is dropped so stray statuses cannot underflow.
   always_comb begin
      w_inc = inc_i && !full_o;
      w_dec = dec_i && !empty_o;
      cnt_d = cnt_q;
      if (w_inc && !w_dec) begin
         cnt_d = cnt_q + C_ONE;
      end else if (w_dec && !w_inc) begin
         cnt_d = cnt_q - C_ONE;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dso100fb_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dso100fb_fetch_ctrl                                                      |
// | Splits one framebuffer per vertical sync into DataMover MM2S commands   |
// | of at most CHUNK_BYTES, limits commands in flight to MAX_OUTST and      |
// | reports frame completion, DataMover errors and frame underruns.         |
// | Ports: CLK, RST_N (async, active-low); FETCH_EN, FRAME_START, FB_BASE,  |
// |        FB_LENGTH (frame request); MCMD_* (command stream out);         |
// |        MSTS_* (status stream in); BUSY, FRAME_DONE, ERR, UNDERRUN,      |
// |        ERR_CLR (status / sticky flags).                                 |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module dso100fb_fetch_ctrl
   import dso100fb_pkg::*;
#(
   parameter int CHUNK_BYTES = 4096,
   parameter int MAX_OUTST   = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        FETCH_EN,
   input  logic        FRAME_START,
   input  logic [31:0] FB_BASE,
   input  logic [22:0] FB_LENGTH,
   output logic [71:0] MCMD_TDATA,
   output logic        MCMD_TVALID,
   input  logic        MCMD_TREADY,
   input  logic [7:0]  MSTS_TDATA,
   input  logic        MSTS_TVALID,
   output logic        MSTS_TREADY,
   output logic        BUSY,
   output logic        FRAME_DONE,
   output logic        ERR,
   output logic        UNDERRUN,
   input  logic        ERR_CLR
);
   localparam logic [CMD_BTT_W-1:0] C_CHUNK = CMD_BTT_W'(CHUNK_BYTES);

   fetch_state_e         state_q, state_d;
   logic [31:0]          ptr_q, ptr_d;
   logic [CMD_BTT_W-1:0] rem_q, rem_d;
   logic [3:0]           tag_q, tag_d;
   logic                 cmd_vld_q, cmd_vld_d;
   logic [CMD_W-1:0]     cmd_q, cmd_d;
   logic                 err_q, err_d;
   logic                 unr_q, unr_d;
   logic                 done_q, done_d;

   logic                 w_accept;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_sts_err;
   logic                 w_unr_set;
   logic [CMD_BTT_W-1:0] w_btt;
   logic [CMD_BTT_W-1:0] w_acc_btt;
   logic                 w_eof;
   logic                 w_sts_tag_unused;

   assign w_accept  = cmd_vld_q && MCMD_TREADY;
   assign w_btt     = (rem_q > C_CHUNK) ? C_CHUNK : rem_q;
   assign w_eof     = (w_btt == rem_q);
   assign w_acc_btt = cmd_q[CMD_BTT_W-1:0];
   // Statuses arriving with nothing outstanding are ignored entirely.
   assign w_sts_err = MSTS_TVALID && !w_empty && sts_is_err(MSTS_TDATA);
   assign w_unr_set = FRAME_START && (state_q != ST_IDLE);
   assign w_sts_tag_unused = ^MSTS_TDATA[3:0];

   dso100fb_outst_cnt #(
      .MAX_CNT (MAX_OUTST)
   ) u_outst_cnt (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .inc_i   (w_accept),
      .dec_i   (MSTS_TVALID),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      tag_d     = tag_q;
      cmd_vld_d = cmd_vld_q;
      cmd_d     = cmd_q;
      done_d    = 1'b0;
      err_d     = w_sts_err ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
      unr_d     = w_unr_set ? 1'b1 : (ERR_CLR ? 1'b0 : unr_q);

      case (state_q)
         ST_IDLE: begin
            if (FRAME_START && FETCH_EN) begin
               if (FB_LENGTH != '0) begin
                  state_d = ST_ISSUE;
                  ptr_d   = FB_BASE;
                  rem_d   = FB_LENGTH;
                  tag_d   = '0;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (w_accept) begin
               // Address/length advance from the field just handed over,
               // so the next command is built one cycle later from fresh state.
               cmd_vld_d = 1'b0;
               ptr_d     = ptr_q + {{(32-CMD_BTT_W){1'b0}}, w_acc_btt};
               rem_d     = rem_q - w_acc_btt;
               tag_d     = tag_q + 4'd1;
               if (cmd_q[CMD_EOF_BIT]) begin
                  state_d = ST_DRAIN;
               end
            end else if (!cmd_vld_q) begin
               if (!FETCH_EN) begin
                  state_d = ST_DRAIN;
               end else if (!w_full) begin
                  cmd_vld_d = 1'b1;
                  cmd_d     = mm2s_cmd(tag_q, ptr_q, w_eof, w_btt);
               end
            end
         end
         ST_DRAIN: begin
            if (w_empty) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         rem_q     <= '0;
         tag_q     <= '0;
         cmd_vld_q <= 1'b0;
         cmd_q     <= '0;
         err_q     <= 1'b0;
         unr_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rem_q     <= rem_d;
         tag_q     <= tag_d;
         cmd_vld_q <= cmd_vld_d;
         cmd_q     <= cmd_d;
         err_q     <= err_d;
         unr_q     <= unr_d;
         done_q    <= done_d;
      end
   end

   assign MCMD_TVALID = cmd_vld_q;
   assign MCMD_TDATA  = cmd_q;
   assign MSTS_TREADY = 1'b1;
   assign BUSY        = (state_q != ST_IDLE);
   assign FRAME_DONE  = done_q;
   assign ERR         = err_q;
   assign UNDERRUN    = unr_q;

endmodule
`default_nettype wire

// File: tb/tb_dso100fb_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dso100fb_fetch_ctrl                                                   |
// | Scoreboard bench: a frame model queues the expected command words and   |
// | FRAME_DONE events; a monitor compares every accepted command and done   |
// | pulse; a responder returns statuses for accepted commands.             |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_dso100fb_fetch_ctrl;
   localparam int CHUNK = 4096;
   localparam int MAXO  = 2;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        FETCH_EN = 1'b0;
   logic        FRAME_START = 1'b0;
   logic [31:0] FB_BASE = '0;
   logic [22:0] FB_LENGTH = '0;
   logic [71:0] MCMD_TDATA;
   logic        MCMD_TVALID;
   logic        MCMD_TREADY = 1'b0;
   logic [7:0]  MSTS_TDATA = '0;
   logic        MSTS_TVALID = 1'b0;
   logic        MSTS_TREADY;
   logic        BUSY;
   logic        FRAME_DONE;
   logic        ERR;
   logic        UNDERRUN;
   logic        ERR_CLR = 1'b0;

   dso100fb_fetch_ctrl #(
      .CHUNK_BYTES (CHUNK),
      .MAX_OUTST   (MAXO)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .FETCH_EN    (FETCH_EN),
      .FRAME_START (FRAME_START),
      .FB_BASE     (FB_BASE),
      .FB_LENGTH   (FB_LENGTH),
      .MCMD_TDATA  (MCMD_TDATA),
      .MCMD_TVALID (MCMD_TVALID),
      .MCMD_TREADY (MCMD_TREADY),
      .MSTS_TDATA  (MSTS_TDATA),
      .MSTS_TVALID (MSTS_TVALID),
      .MSTS_TREADY (MSTS_TREADY),
      .BUSY        (BUSY),
      .FRAME_DONE  (FRAME_DONE),
      .ERR         (ERR),
      .UNDERRUN    (UNDERRUN),
      .ERR_CLR     (ERR_CLR)
   );

   always #5 CLK = ~CLK;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [71:0] exp_cmd_q[$];
   int          exp_done_q[$];
   logic [7:0]  sts_q[$];
   int          err_req_q[$];     // tags whose status is returned as an error
   logic [71:0] acc_log[$];
   int          rdy_mode = 1;     // 0 low, 1 high, 2 random
   bit          sts_hold = 1'b0;
   logic        mon_pv = 1'b0;
   logic [71:0] mon_pd = '0;
   logic        exp_err = 1'b0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input string msg);
      n_fail++;
      $display("FAIL %s: %s", name, msg);
   endtask

   // Reference model: chop the frame into CHUNK pieces with plain arithmetic.
   task automatic model_frame(input logic [31:0] base, input int len);
      logic [31:0] a;
      int          rem;
      int          tag;
      int          btt;
      a   = base;
      rem = len;
      tag = 0;
      while (rem > 0) begin
         btt = (rem < CHUNK) ? rem : CHUNK;
         exp_cmd_q.push_back({4'h0, 4'(tag), a, 1'b0, (btt == rem), 6'h00, 1'b1, 23'(btt)});
         a   = a + 32'(btt);
         rem = rem - btt;
         tag = (tag + 1) % 16;
      end
      exp_done_q.push_back(1);
   endtask

   task automatic pulse_start(input logic [31:0] base, input int len, input bit modelled);
      @(posedge CLK); #1;
      FRAME_START = 1'b1;
      FB_BASE     = base;
      FB_LENGTH   = 23'(len);
      if (modelled) model_frame(base, len);
      @(posedge CLK); #1;
      FRAME_START = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge CLK); #1;
      ERR_CLR = 1'b1;
      @(posedge CLK); #1;
      ERR_CLR = 1'b0;
   endtask

   task automatic wait_not_busy(input string name);
      int n;
      n = 0;
      @(negedge CLK);
      while (BUSY && n < 4000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 4000) flag(name, "timeout waiting for BUSY to fall");
      repeat (4) @(negedge CLK);
   endtask

   task automatic wait_idle(input string name);
      wait_not_busy(name);
      check({name, "_cmds_left"}, 72'(exp_cmd_q.size()), 72'd0);
      check({name, "_done_left"}, 72'(exp_done_q.size()), 72'd0);
   endtask

   task automatic wait_tvalid(input string name);
      int n;
      n = 0;
      @(negedge CLK);
      while (!MCMD_TVALID && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) flag(name, "timeout waiting for MCMD_TVALID");
   endtask

   // Command ready driver
   initial forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
         0:       MCMD_TREADY = 1'b0;
         1:       MCMD_TREADY = 1'b1;
         default: MCMD_TREADY = 1'($urandom_range(0, 1));
      endcase
   end

   // Status responder: returns queued statuses with random gaps.
   initial forever begin
      @(posedge CLK); #1;
      if (!sts_hold && sts_q.size() > 0 && $urandom_range(0, 2) != 0) begin
         MSTS_TVALID = 1'b1;
         MSTS_TDATA  = sts_q.pop_front();
      end else begin
         MSTS_TVALID = 1'b0;
      end
   end

   // Monitor / scoreboard
   initial forever begin
      logic [7:0] s;
      @(negedge CLK);
      if (!RST_N) begin
         mon_pv = 1'b0;
      end else begin
         if (mon_pv) begin
            check("hold_tvalid", 72'(MCMD_TVALID), 72'd1);
            check("hold_tdata", MCMD_TDATA, mon_pd);
         end
         if (MCMD_TVALID && MCMD_TREADY) begin
            acc_log.push_back(MCMD_TDATA);
            n_cmp++;
            if (exp_cmd_q.size() == 0) begin
               n_fail++;
               $display("FAIL cmd_unexpected: got %0h required none", MCMD_TDATA);
            end else begin
               n_cmp--;
               check("cmd", MCMD_TDATA, exp_cmd_q.pop_front());
            end
            s = {4'h8, MCMD_TDATA[67:64]};
            if (err_req_q.size() > 0 && err_req_q[0] == int'(MCMD_TDATA[67:64])) begin
               void'(err_req_q.pop_front());
               s = {4'h4, MCMD_TDATA[67:64]};
            end
            sts_q.push_back(s);
         end
         if (FRAME_DONE) begin
            n_cmp++;
            if (exp_done_q.size() == 0) begin
               n_fail++;
               $display("FAIL done_unexpected: got FRAME_DONE=1 required 0");
            end else begin
               void'(exp_done_q.pop_front());
            end
         end
         mon_pv = MCMD_TVALID && !MCMD_TREADY;
         mon_pd = MCMD_TDATA;
      end
   end

   initial begin
      logic [31:0] base;
      int          len;

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_tvalid", 72'(MCMD_TVALID), 72'd0);
      check("rst_busy", 72'(BUSY), 72'd0);
      check("rst_done", 72'(FRAME_DONE), 72'd0);
      check("rst_err", 72'(ERR), 72'd0);
      check("rst_unr", 72'(UNDERRUN), 72'd0);
      check("rst_sts_ready", 72'(MSTS_TREADY), 72'd1);
      @(posedge CLK); #1;
      RST_N    = 1'b1;
      FETCH_EN = 1'b1;

      // Single frame, exact command words
      acc_log.delete();
      pulse_start(32'h1000_0000, 10000, 1'b1);
      wait_idle("single");
      check("single_ncmd", 72'(acc_log.size()), 72'd3);
      if (acc_log.size() >= 3) begin
         check("single_c0", acc_log[0], 72'h00_10000000_00801000);
         check("single_c1", acc_log[1], 72'h01_10001000_00801000);
         check("single_c2", acc_log[2], 72'h02_10002000_40800710);
      end
      check("single_err", 72'(ERR), 72'd0);

      // Zero-length frame: done pulse, no command
      acc_log.delete();
      pulse_start(32'h2000_0000, 0, 1'b1);
      wait_idle("zero");
      check("zero_ncmd", 72'(acc_log.size()), 72'd0);

      // Stray status with nothing outstanding
      sts_q.push_back(8'h80);
      repeat (10) @(negedge CLK);
      check("stray_err", 72'(ERR), 72'd0);

      // Backpressure: statuses withheld, ready low for 5 cycles
      rdy_mode = 0;
      sts_hold = 1'b1;
      acc_log.delete();
      pulse_start(32'h3000_0000, 20000, 1'b1);
      wait_tvalid("bp");
      repeat (5) @(negedge CLK);
      check("bp_tdata_head", MCMD_TDATA, exp_cmd_q[0]);
      rdy_mode = 1;
      repeat (30) @(negedge CLK);
      check("bp_ncmd", 72'(acc_log.size()), 72'(MAXO));
      check("bp_tvalid_off", 72'(MCMD_TVALID), 72'd0);
      sts_hold = 1'b0;
      wait_idle("bp");

      // Error status 0x41 (tag 1), frame still completes
      err_req_q.push_back(1);
      pulse_start(32'h4000_0000, 12288, 1'b1);
      wait_idle("err");
      check("err_set", 72'(ERR), 72'd1);
      pulse_clr();
      @(negedge CLK);
      check("err_clr", 72'(ERR), 72'd0);

      // FRAME_START while busy: underrun, stream unchanged
      rdy_mode = 2;
      pulse_start(32'h5000_0000, 30000, 1'b1);
      repeat (5) @(negedge CLK);
      pulse_start(32'h6000_0000, 100, 1'b0);
      @(negedge CLK);
      check("unr_set", 72'(UNDERRUN), 72'd1);
      // Clear and set in the same cycle: set wins
      @(posedge CLK); #1;
      ERR_CLR = 1'b1;
      FRAME_START = 1'b1;
      @(posedge CLK); #1;
      ERR_CLR = 1'b0;
      FRAME_START = 1'b0;
      @(negedge CLK);
      check("unr_set_wins", 72'(UNDERRUN), 72'd1);
      wait_idle("unr");
      pulse_clr();
      @(negedge CLK);
      check("unr_clr", 72'(UNDERRUN), 72'd0);

      // 32-bit address wrap
      rdy_mode = 1;
      acc_log.delete();
      pulse_start(32'hFFFF_F000, 8192, 1'b1);
      wait_idle("wrap");
      if (acc_log.size() >= 2) check("wrap_addr", 72'(acc_log[1][63:32]), 72'd0);
      else flag("wrap_addr", "fewer than 2 commands accepted");

      // Reset with a command pending
      rdy_mode = 0;
      pulse_start(32'h7000_0000, 9000, 1'b1);
      wait_tvalid("rst_mid");
      @(posedge CLK); #2;
      RST_N = 1'b0;
      #1;
      check("rst_mid_tvalid", 72'(MCMD_TVALID), 72'd0);
      check("rst_mid_busy", 72'(BUSY), 72'd0);
      exp_cmd_q.delete();
      exp_done_q.delete();
      sts_q.delete();
      err_req_q.delete();
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      rdy_mode = 1;
      acc_log.delete();
      pulse_start(32'h7100_0000, 5000, 1'b1);
      wait_idle("rst_fresh");
      if (acc_log.size() >= 1) check("rst_fresh_tag", 72'(acc_log[0][67:64]), 72'd0);
      else flag("rst_fresh_tag", "no command accepted");

      // FETCH_EN dropped mid-frame: truncated prefix, frame still finishes
      rdy_mode = 2;
      acc_log.delete();
      pulse_start(32'h8000_0000, 40000, 1'b1);
      repeat (6) @(negedge CLK);
      @(posedge CLK); #1;
      FETCH_EN = 1'b0;
      wait_not_busy("en_drop");
      exp_cmd_q.delete();
      check("en_drop_done_left", 72'(exp_done_q.size()), 72'd0);
      check("en_drop_truncated", 72'(acc_log.size() < 10), 72'd1);
      // FRAME_START while disabled: no command, no done
      pulse_start(32'h9000_0000, 4096, 1'b0);
      repeat (10) @(negedge CLK);
      check("dis_busy", 72'(BUSY), 72'd0);
      FETCH_EN = 1'b1;

      // Randomised frames
      for (int i = 0; i < 8; i++) begin
         base    = $urandom;
         len     = int'($urandom_range(1, 20000));
         exp_err = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            err_req_q.push_back(0);
            exp_err = 1'b1;
         end
         pulse_start(base, len, 1'b1);
         wait_idle("rand");
         check("rand_err", 72'(ERR), 72'(exp_err));
         pulse_clr();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
